// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction controller: FSM encoding and coin decoding.
package vend_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CREDIT = 2'd1;
    localparam logic [1:0] ST_VEND   = 2'd2;
    localparam logic [1:0] ST_CHANGE = 2'd3;

    localparam logic [1:0] COIN_5  = 2'd0;
    localparam logic [1:0] COIN_10 = 2'd1;
    localparam logic [1:0] COIN_25 = 2'd2;
    localparam logic [1:0] COIN_50 = 2'd3;

    localparam int unsigned COIN_VAL_W = 6;

    // Map a coin code to its monetary value.
    function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] code);
        logic [COIN_VAL_W-1:0] v;
        v = COIN_VAL_W'(5);
        case (code)
            COIN_5:  v = COIN_VAL_W'(5);
            COIN_10: v = COIN_VAL_W'(10);
            COIN_25: v = COIN_VAL_W'(25);
            COIN_50: v = COIN_VAL_W'(50);
            default: v = COIN_VAL_W'(5);
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters: reset to full, decrement on vend, restock to full (restock wins).
module vend_stock_bank #(
    parameter int unsigned N       = 2,
    parameter int unsigned STOCK_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    input  logic [N-1:0]      dec_sel,
    input  logic              restock_valid,
    input  logic [N-1:0]      restock_sel,
    output logic [(2**N)-1:0] empty_c
);

    localparam int unsigned NI = 2**N;

    logic [STOCK_W-1:0] cnt [NI];

    // Counter update; restock overrides a same-cycle decrement of the same item.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NI; i++) begin
                cnt[i] <= '1;
            end
        end else begin
            for (int unsigned i = 0; i < NI; i++) begin
                if (restock_valid && (restock_sel == N'(i))) begin
                    cnt[i] <= '1;
                end else if (dec_valid && (dec_sel == N'(i)) && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - STOCK_W'(1);
                end
            end
        end
    end

    // Empty flags straight from the counters.
    always_comb begin
        for (int unsigned i = 0; i < NI; i++) begin
            empty_c[i] = (cnt[i] == '0);
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction controller: coin credit, price/stock checked selection, vend pulse, change handshake.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned N        = 2,
    parameter int unsigned CREDIT_W = 8,
    parameter int unsigned STOCK_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       coin_valid,
    input  logic [1:0]                 coin_type,
    input  logic                       sel_valid,
    input  logic [N-1:0]               sel,
    input  logic                       cancel,
    input  logic [(2**N)*CREDIT_W-1:0] price_tbl,
    input  logic                       restock_valid,
    input  logic [N-1:0]               restock_sel,
    input  logic                       change_ack,
    output logic [N-1:0]               vend_sel,
    output logic                       vend_en,
    output logic                       change_valid,
    output logic [CREDIT_W-1:0]        change_amt,
    output logic [CREDIT_W-1:0]        credit,
    output logic                       coin_reject,
    output logic                       insufficient,
    output logic                       sold_out
);

    localparam int unsigned NI    = 2**N;
    localparam int unsigned WIDE_W = CREDIT_W + 1;
    localparam logic [WIDE_W-1:0] CREDIT_MAX = WIDE_W'((2**CREDIT_W) - 1);

    logic [1:0]          state, state_d;
    logic [CREDIT_W-1:0] credit_d, change_amt_d;
    logic [N-1:0]        vend_sel_d;
    logic                vend_en_d, change_valid_d;
    logic                coin_reject_d, insufficient_d, sold_out_d;
    logic [WIDE_W-1:0]   coin_sum_c, sel_price_c;
    logic [CREDIT_W-1:0] price [NI];
    logic [NI-1:0]       empty_c;

    // Unpack the flattened price table.
    always_comb begin
        for (int unsigned i = 0; i < NI; i++) begin
            price[i] = price_tbl[i*CREDIT_W +: CREDIT_W];
        end
    end

    vend_stock_bank #(
        .N       (N),
        .STOCK_W (STOCK_W)
    ) u_stock (
        .clk           (clk),
        .rst_n         (rst_n),
        .dec_valid     (state == ST_VEND),
        .dec_sel       (vend_sel),
        .restock_valid (restock_valid),
        .restock_sel   (restock_sel),
        .empty_c       (empty_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            credit       <= '0;
            vend_sel     <= '0;
            vend_en      <= 1'b0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            sold_out     <= 1'b0;
        end else begin
            state        <= state_d;
            credit       <= credit_d;
            vend_sel     <= vend_sel_d;
            vend_en      <= vend_en_d;
            change_valid <= change_valid_d;
            change_amt   <= change_amt_d;
            coin_reject  <= coin_reject_d;
            insufficient <= insufficient_d;
            sold_out     <= sold_out_d;
        end
    end

    // Next state and next outputs; one event per cycle, cancel > coin > sel.
    always_comb begin
        state_d        = state;
        credit_d       = credit;
        vend_sel_d     = vend_sel;
        vend_en_d      = 1'b0;
        change_valid_d = change_valid;
        change_amt_d   = change_amt;
        coin_reject_d  = 1'b0;
        insufficient_d = 1'b0;
        sold_out_d     = 1'b0;
        coin_sum_c     = {1'b0, credit} + WIDE_W'(coin_value(coin_type));
        sel_price_c    = {1'b0, price[sel]};

        case (state)
            ST_IDLE, ST_CREDIT: begin
                if (cancel) begin
                    if (state == ST_CREDIT) begin
                        state_d        = ST_CHANGE;
                        change_valid_d = 1'b1;
                        change_amt_d   = credit;
                    end
                end else if (coin_valid) begin
                    if (coin_sum_c > CREDIT_MAX) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = coin_sum_c[CREDIT_W-1:0];
                        state_d  = ST_CREDIT;
                    end
                end else if (sel_valid) begin
                    if (empty_c[sel]) begin
                        sold_out_d = 1'b1;
                    end else if ({1'b0, credit} < sel_price_c) begin
                        insufficient_d = 1'b1;
                    end else begin
                        vend_sel_d = sel;
                        vend_en_d  = 1'b1;
                        credit_d   = credit - price[sel];
                        state_d    = ST_VEND;
                    end
                end
            end
            ST_VEND: begin
                coin_reject_d = coin_valid;
                if (credit != '0) begin
                    state_d        = ST_CHANGE;
                    change_valid_d = 1'b1;
                    change_amt_d   = credit;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHANGE: begin
                coin_reject_d = coin_valid;
                if (change_ack) begin
                    state_d        = ST_IDLE;
                    credit_d       = '0;
                    change_valid_d = 1'b0;
                    change_amt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
